// File: rtl/melody_player.sv
// Table-driven square-wave melody generator: plays a writable note table REPEATS times,
// then idles for PAUSE_CYC cycles, and loops for as long as en stays high.
module melody_player #(
  parameter int NOTES     = 32,
  parameter int HP_W      = 20,
  parameter int DUR_W     = 28,
  parameter int REPEATS   = 2,
  parameter int PAUSE_CYC = 1_500_000_000,
  parameter int PAUSE_W   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     wr_en,
  input  logic [$clog2(NOTES)-1:0] wr_addr,
  input  logic [HP_W-1:0]          wr_half,
  input  logic [DUR_W-1:0]         wr_dur,
  input  logic                     wr_last,
  output logic                     melody,
  output logic                     busy,
  output logic [$clog2(NOTES)-1:0] note_idx
);

  localparam int AW    = $clog2(NOTES);
  localparam int EW    = HP_W + DUR_W + 1;
  localparam int REP_W = (REPEATS > 1) ? $clog2(REPEATS) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, PAUSE = 2'd2} state_t;

  state_t              state_reg, state_next;
  logic [AW-1:0]       note_idx_reg, note_idx_next;
  logic [REP_W-1:0]    rep_reg, rep_next;
  logic [HP_W-1:0]     hp_cnt_reg, hp_cnt_next;
  logic [DUR_W-1:0]    dur_cnt_reg, dur_cnt_next;
  logic [PAUSE_W-1:0]  pause_cnt_reg, pause_cnt_next;
  logic                melody_reg, melody_next;

  logic [EW-1:0]       note_mem [NOTES];
  logic [EW-1:0]       cur_reg;
  logic                fetch;
  logic [AW-1:0]       rd_addr;

  logic [HP_W-1:0]     cur_half;
  logic [DUR_W-1:0]    cur_dur;
  logic                cur_last;
  logic [DUR_W-1:0]    dur_lim;

  assign cur_half = cur_reg[HP_W-1:0];
  assign cur_dur  = cur_reg[HP_W +: DUR_W];
  assign cur_last = cur_reg[EW-1];
  assign dur_lim  = (cur_dur == '0) ? '0 : cur_dur - DUR_W'(1);

  // The playing note is a registered copy of its entry, so rewriting that entry
  // only takes effect the next time it is fetched.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      note_mem[wr_addr] <= {wr_last, wr_dur, wr_half};
    end
    if (fetch) begin
      cur_reg <= note_mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      note_idx_reg  <= '0;
      rep_reg       <= '0;
      hp_cnt_reg    <= '0;
      dur_cnt_reg   <= '0;
      pause_cnt_reg <= '0;
      melody_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      note_idx_reg  <= note_idx_next;
      rep_reg       <= rep_next;
      hp_cnt_reg    <= hp_cnt_next;
      dur_cnt_reg   <= dur_cnt_next;
      pause_cnt_reg <= pause_cnt_next;
      melody_reg    <= melody_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    note_idx_next  = note_idx_reg;
    rep_next       = rep_reg;
    hp_cnt_next    = hp_cnt_reg;
    dur_cnt_next   = dur_cnt_reg;
    pause_cnt_next = pause_cnt_reg;
    melody_next    = melody_reg;
    fetch          = 1'b0;
    rd_addr        = '0;
    if (!en) begin
      state_next     = IDLE;
      note_idx_next  = '0;
      rep_next       = '0;
      hp_cnt_next    = '0;
      dur_cnt_next   = '0;
      pause_cnt_next = '0;
      melody_next    = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next     = PLAY;
          note_idx_next  = '0;
          rep_next       = '0;
          hp_cnt_next    = '0;
          dur_cnt_next   = '0;
          pause_cnt_next = '0;
          melody_next    = 1'b0;
          fetch          = 1'b1;
        end
        PLAY: begin
          if (dur_cnt_reg == dur_lim) begin
            melody_next  = 1'b0;
            hp_cnt_next  = '0;
            dur_cnt_next = '0;
            if (cur_last || note_idx_reg == AW'(NOTES - 1)) begin
              note_idx_next = '0;
              if (rep_reg != REP_W'(REPEATS - 1)) begin
                rep_next = rep_reg + REP_W'(1);
                fetch    = 1'b1;
              end else begin
                rep_next = '0;
                if (PAUSE_CYC != 0) begin
                  state_next     = PAUSE;
                  pause_cnt_next = '0;
                end else begin
                  fetch = 1'b1;
                end
              end
            end else begin
              note_idx_next = note_idx_reg + AW'(1);
              rd_addr       = note_idx_reg + AW'(1);
              fetch         = 1'b1;
            end
          end else begin
            dur_cnt_next = dur_cnt_reg + DUR_W'(1);
            if (cur_half != '0 && hp_cnt_reg == cur_half - HP_W'(1)) begin
              melody_next = ~melody_reg;
              hp_cnt_next = '0;
            end else begin
              hp_cnt_next = hp_cnt_reg + HP_W'(1);
            end
          end
        end
        PAUSE: begin
          melody_next = 1'b0;
          if (pause_cnt_reg == PAUSE_W'(PAUSE_CYC - 1)) begin
            state_next     = PLAY;
            note_idx_next  = '0;
            rep_next       = '0;
            pause_cnt_next = '0;
            fetch          = 1'b1;
          end else begin
            pause_cnt_next = pause_cnt_reg + PAUSE_W'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign melody   = melody_reg;
  assign busy     = (state_reg != IDLE);
  assign note_idx = note_idx_reg;

endmodule

// File: tb/tb_melody_player.sv
// Directed bench for melody_player with NOTES=4, REPEATS=2, PAUSE_CYC=20.
module tb_melody_player;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_addr = '0;
  logic [19:0] wr_half = '0;
  logic [27:0] wr_dur = '0;
  logic        wr_last = 1'b0;
  logic        melody;
  logic        busy;
  logic [1:0]  note_idx;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  melody_player #(
    .NOTES(4), .HP_W(20), .DUR_W(28), .REPEATS(2), .PAUSE_CYC(20), .PAUSE_W(32)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_half(wr_half), .wr_dur(wr_dur), .wr_last(wr_last),
    .melody(melody), .busy(busy), .note_idx(note_idx)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input logic [1:0] a, input int h, input int d, input logic l);
    wr_en = 1'b1; wr_addr = a; wr_half = 20'(h); wr_dur = 28'(d); wr_last = l;
    tick();
    wr_en = 1'b0;
  endtask

  // Expected index/level for the 4-note song {3,6},{0,4},{2,4},{5,10}, by song cycle.
  function automatic int song_idx(input int c);
    if (c < 6) return 0;
    if (c < 10) return 1;
    if (c < 14) return 2;
    return 3;
  endfunction

  function automatic logic song_mel(input int c);
    logic [23:0] p;
    p = 24'b1111_1000_0011_0000_0011_1000;
    return p[c];
  endfunction

  task automatic test_reset;
    rst = 1'b1; en = 1'b1;
    tick(); tick();
    total++; if (melody !== 1'b0) begin bad++; $display("FAIL reset_mel got=%b exp=0", melody); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (note_idx !== 2'd0) begin bad++; $display("FAIL reset_idx got=%0d exp=0", note_idx); end
    rst = 1'b0; en = 1'b0;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b exp=0", busy); end
    $display("reset: melody=%b busy=%b idx=%0d", melody, busy, note_idx);
  endtask

  task automatic test_basic;
    logic [11:0] p3;
    p3 = 12'b1110_0011_1000;
    write_entry(2'd0, 3, 12, 1'b1);
    en = 1'b1;
    tick();
    for (int c = 0; c < 24; c++) begin
      total++; if (melody !== p3[c % 12]) begin bad++; $display("FAIL basic_mel c=%0d got=%b exp=%b", c, melody, p3[c % 12]); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy c=%0d got=%b exp=1", c, busy); end
      total++; if (note_idx !== 2'd0) begin bad++; $display("FAIL basic_idx c=%0d got=%0d exp=0", c, note_idx); end
      tick();
    end
    for (int c = 0; c < 20; c++) begin
      total++; if (melody !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL basic_pause c=%0d got mel=%b busy=%b exp mel=0 busy=1", c, melody, busy); end
      total++; if (dut.state_reg !== 2'd2) begin bad++; $display("FAIL basic_pause_state c=%0d got=%0d exp=2", c, dut.state_reg); end
      tick();
    end
    total++; if (dut.state_reg !== 2'd1 || melody !== 1'b0) begin bad++; $display("FAIL basic_restart got state=%0d mel=%b exp state=1 mel=0", dut.state_reg, melody); end
    tick(); tick(); tick();
    total++; if (melody !== 1'b1) begin bad++; $display("FAIL basic_restart_tone got=%b exp=1", melody); end
    en = 1'b0;
    tick();
    $display("basic: single-note song, two plays, pause, restart checked");
  endtask

  task automatic test_notes;
    write_entry(2'd0, 3, 6, 1'b0);
    write_entry(2'd1, 0, 4, 1'b0);
    write_entry(2'd2, 2, 4, 1'b0);
    write_entry(2'd3, 5, 10, 1'b0);
    en = 1'b1;
    tick();
    for (int c = 0; c < 48; c++) begin
      total++; if (melody !== song_mel(c % 24)) begin bad++; $display("FAIL notes_mel c=%0d got=%b exp=%b", c, melody, song_mel(c % 24)); end
      total++; if (note_idx !== 2'(song_idx(c % 24))) begin bad++; $display("FAIL notes_idx c=%0d got=%0d exp=%0d", c, note_idx, song_idx(c % 24)); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL notes_busy c=%0d got=%b exp=1", c, busy); end
      tick();
    end
    for (int c = 0; c < 20; c++) begin
      total++; if (dut.state_reg !== 2'd2 || melody !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL notes_pause c=%0d got state=%0d mel=%b busy=%b", c, dut.state_reg, melody, busy); end
      tick();
    end
    total++; if (dut.state_reg !== 2'd1 || note_idx !== 2'd0) begin bad++; $display("FAIL notes_restart got state=%0d idx=%0d exp state=1 idx=0", dut.state_reg, note_idx); end
    en = 1'b0;
    tick();
    $display("notes: four-entry song with wrap and rest checked");
  endtask

  task automatic test_en_drop;
    en = 1'b1;
    tick();
    repeat (11) tick();
    total++; if (note_idx !== 2'd2) begin bad++; $display("FAIL drop_mid_idx got=%0d exp=2", note_idx); end
    en = 1'b0;
    tick();
    total++; if (melody !== 1'b0 || busy !== 1'b0 || note_idx !== 2'd0) begin bad++; $display("FAIL drop_idle got mel=%b busy=%b idx=%0d exp 0/0/0", melody, busy, note_idx); end
    en = 1'b1;
    tick();
    for (int c = 0; c < 48; c++) begin
      total++; if (melody !== song_mel(c % 24) || note_idx !== 2'(song_idx(c % 24))) begin bad++; $display("FAIL drop_replay c=%0d got mel=%b idx=%0d exp mel=%b idx=%0d", c, melody, note_idx, song_mel(c % 24), song_idx(c % 24)); end
      tick();
    end
    total++; if (dut.state_reg !== 2'd2) begin bad++; $display("FAIL drop_pause got=%0d exp=2", dut.state_reg); end
    $display("en_drop: abort to idle and full restart checked");
  endtask

  task automatic test_rst_pause;
    tick(); tick(); tick();
    rst = 1'b1;
    wr_en = 1'b1; wr_addr = 2'd1; wr_half = 20'd7; wr_dur = 28'd9; wr_last = 1'b1;
    tick();
    rst = 1'b0; wr_en = 1'b0;
    total++; if (melody !== 1'b0 || busy !== 1'b0 || note_idx !== 2'd0) begin bad++; $display("FAIL rst_idle got mel=%b busy=%b idx=%0d exp 0/0/0", melody, busy, note_idx); end
    tick();
    total++; if (dut.state_reg !== 2'd1 || busy !== 1'b1 || note_idx !== 2'd0) begin bad++; $display("FAIL rst_play got state=%0d busy=%b idx=%0d exp 1/1/0", dut.state_reg, busy, note_idx); end
    for (int c = 0; c < 24; c++) begin
      total++; if (melody !== song_mel(c) || note_idx !== 2'(song_idx(c))) begin bad++; $display("FAIL rst_table c=%0d got mel=%b idx=%0d exp mel=%b idx=%0d", c, melody, note_idx, song_mel(c), song_idx(c)); end
      tick();
    end
    en = 1'b0;
    tick();
    $display("rst_pause: reset in pause, dropped write, table kept checked");
  endtask

  task automatic test_live_write;
    logic [11:0] p3;
    logic [11:0] p5;
    p3 = 12'b1110_0011_1000;
    p5 = 12'b0011_1110_0000;
    write_entry(2'd0, 3, 12, 1'b1);
    en = 1'b1;
    tick();
    for (int c = 0; c < 12; c++) begin
      total++; if (melody !== p3[c]) begin bad++; $display("FAIL live_old c=%0d got=%b exp=%b", c, melody, p3[c]); end
      if (c == 2) begin
        wr_en = 1'b1; wr_addr = 2'd0; wr_half = 20'd5; wr_dur = 28'd12; wr_last = 1'b1;
      end
      tick();
      wr_en = 1'b0;
    end
    for (int c = 0; c < 12; c++) begin
      total++; if (melody !== p5[c]) begin bad++; $display("FAIL live_new c=%0d got=%b exp=%b", c, melody, p5[c]); end
      tick();
    end
    en = 1'b0;
    tick();
    $display("live_write: rewrite of playing entry deferred to next fetch checked");
  endtask

  task automatic test_zero_dur;
    write_entry(2'd0, 2, 0, 1'b1);
    en = 1'b1;
    tick();
    total++; if (dut.state_reg !== 2'd1 || dut.rep_reg !== 1'b0 || melody !== 1'b0) begin bad++; $display("FAIL zd_c0 got state=%0d rep=%0d mel=%b exp 1/0/0", dut.state_reg, dut.rep_reg, melody); end
    tick();
    total++; if (dut.state_reg !== 2'd1 || dut.rep_reg !== 1'b1 || melody !== 1'b0) begin bad++; $display("FAIL zd_c1 got state=%0d rep=%0d mel=%b exp 1/1/0", dut.state_reg, dut.rep_reg, melody); end
    tick();
    total++; if (dut.state_reg !== 2'd2 || busy !== 1'b1 || melody !== 1'b0) begin bad++; $display("FAIL zd_pause got state=%0d busy=%b mel=%b exp 2/1/0", dut.state_reg, busy, melody); end
    en = 1'b0;
    tick();
    $display("zero_dur: one-cycle notes and pause entry checked");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_notes();
    test_en_drop();
    test_rst_pause();
    test_live_write();
    test_zero_dur();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
